// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the TX framer and RX side.
// Rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational even/odd parity of a DATA_W-bit word.
// Rev 1.0
`default_nettype none

module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_typ_i,
  output logic              par_o
);

  // Even parity is the XOR of the data; odd parity is its complement.
  assign par_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

`default_nettype wire

// File: rtl/uart_frame_ser.sv
// uart_frame_ser: parametrised UART TX framer (start, data, optional parity, stop bits).
// Rev 1.0
`default_nettype none

module uart_frame_ser
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  output logic              ready,
  output logic              busy,
  output logic              tx_out,
  output logic              frame_done
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $fatal(1, "uart_frame_ser: DATA_W must be within 5..9");
  end

  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $fatal(1, "uart_frame_ser: STOP_BITS must be 1 or 2");
  end

  tx_state_e          state_q;
  logic [DATA_W-1:0]  shreg_q;
  logic [DATA_W-1:0]  shreg_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               stop_q;
  logic               par_en_q;
  logic               par_bit_q;
  logic               busy_q;
  logic               tx_q;
  logic               done_q;
  logic               cur_bit;
  logic               par_bit;

  uart_parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data_i    (p_data),
    .par_typ_i (par_typ),
    .par_o     (par_bit)
  );

  // The shift register always presents the next bit to send at one fixed end.
  if (LSB_FIRST) begin : g_lsb_first
    assign cur_bit = shreg_q[0];
    assign shreg_d = {1'b1, shreg_q[DATA_W-1:1]};
  end else begin : g_msb_first
    assign cur_bit = shreg_q[DATA_W-1];
    assign shreg_d = {shreg_q[DATA_W-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shreg_q   <= '1;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Acceptance ignores tick so the frame always starts from a full ARM wait.
        IDLE: begin
          if (data_valid) begin
            shreg_q   <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= par_bit;
            busy_q    <= 1'b1;
            state_q   <= ARM;
          end
        end
        ARM: begin
          if (tick) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= cur_bit;
            shreg_q <= shreg_d;
            cnt_q   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt_q == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              tx_q    <= cur_bit;
              shreg_q <= shreg_d;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_q == LAST_STOP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = busy_q;
  assign tx_out     = tx_q;
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_ser.sv
// tb_uart_frame_ser: scoreboard bench for uart_frame_ser (LSB/1-stop and MSB/2-stop builds).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_uart_frame_ser;

  typedef struct packed {
    logic tx;
    logic last;
  } ent_t;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       tick  = 1'b1;
  logic [1:0] dv    = 2'b00;
  logic [1:0] pen   = 2'b00;
  logic [1:0] ptyp  = 2'b00;
  logic [7:0] pdata0 = 8'h00;
  logic [7:0] pdata1 = 8'h00;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] rdy;
  logic [1:0] done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  ent_t q0[$];
  ent_t q1[$];
  logic [1:0] in_frame = 2'b00;
  logic [1:0] cur_tx   = 2'b11;
  logic [1:0] dv_e     = 2'b00;
  logic       tick_e   = 1'b0;
  int acc_cyc[2]  = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int acc_cnt[2]  = '{0, 0};

  uart_frame_ser #(
    .DATA_W    (8),
    .STOP_BITS (1),
    .LSB_FIRST (1'b1)
  ) dut0 (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .p_data     (pdata0),
    .data_valid (dv[0]),
    .par_en     (pen[0]),
    .par_typ    (ptyp[0]),
    .ready      (rdy[0]),
    .busy       (busy[0]),
    .tx_out     (tx[0]),
    .frame_done (done[0])
  );

  uart_frame_ser #(
    .DATA_W    (8),
    .STOP_BITS (2),
    .LSB_FIRST (1'b0)
  ) dut1 (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .p_data     (pdata1),
    .data_valid (dv[1]),
    .par_en     (pen[1]),
    .par_typ    (ptyp[1]),
    .ready      (rdy[1]),
    .busy       (busy[1]),
    .tx_out     (tx[1]),
    .frame_done (done[1])
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick_cnt++;
    tick = ((tick_cnt % tick_div) == 0);
  end

  initial forever begin
    @(posedge clk);
    tick_e = tick;
    dv_e   = dv;
    cyc++;
  end

  // Per-cycle monitor: one scoreboard entry is consumed on every tick edge inside a frame.
  initial begin
    ent_t       e;
    logic [3:0] got_v;
    logic [3:0] exp_v;
    logic       empty;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        got_v = {tx[d], busy[d], rdy[d], done[d]};
        empty = 1'b0;
        if (!rstn) begin
          in_frame[d] = 1'b0;
          exp_v = 4'b1010;
        end else if (!in_frame[d]) begin
          if (dv_e[d]) begin
            in_frame[d] = 1'b1;
            cur_tx[d]   = 1'b1;
            acc_cyc[d]  = cyc;
            acc_cnt[d]++;
            exp_v = 4'b1100;
          end else begin
            exp_v = 4'b1010;
          end
        end else if (tick_e) begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            e = '0;
            in_frame[d] = 1'b0;
          end else if (d == 0) begin
            e = q0.pop_front();
          end else begin
            e = q1.pop_front();
          end
          exp_v = {e.tx, ~e.last, e.last, e.last};
          cur_tx[d] = e.tx;
          if (e.last) begin
            in_frame[d] = 1'b0;
            done_cyc[d] = cyc;
          end
        end else begin
          exp_v = {cur_tx[d], 1'b1, 1'b0, 1'b0};
        end
        n_checks++;
        if (empty)
          $display("FAIL mon_underflow dut%0d cyc %0d: tick inside frame, got no expected entry, required one", d, cyc);
        else if (got_v !== exp_v)
          $display("FAIL mon dut%0d cyc %0d: tx/busy/ready/done got %b, required %b", d, cyc, got_v, exp_v);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_ent(input int d, input logic t, input logic l);
    ent_t e;
    e.tx   = t;
    e.last = l;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected line value after each tick edge: start, data, parity, stop periods, frame end.
  task automatic push_frame(input int d, input logic [7:0] w, input logic pe, input logic pt);
    int sb;
    sb = (d == 0) ? 1 : 2;
    push_ent(d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      push_ent(d, (d == 0) ? w[i] : w[7-i], 1'b0);
    if (pe) push_ent(d, (^w) ^ pt, 1'b0);
    for (int i = 0; i < sb; i++)
      push_ent(d, 1'b1, 1'b0);
    push_ent(d, 1'b1, 1'b1);
  endtask

  task automatic start_frame(input int d, input logic [7:0] w, input logic pe, input logic pt);
    push_frame(d, w, pe, pt);
    @(negedge clk);
    dv[d] = 1'b1; pen[d] = pe; ptyp[d] = pt;
    if (d == 0) pdata0 = w; else pdata1 = w;
    @(negedge clk);
    dv[d] = 1'b0; pen[d] = ~pe; ptyp[d] = ~pt;
    if (d == 0) pdata0 = ~w; else pdata1 = ~w;
  endtask

  task automatic wait_frames(input int d, input int budget);
    int k;
    k = 0;
    while (k < budget && (in_frame[d] || ((d == 0) ? q0.size() : q1.size()) != 0)) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_checks++;
    if (k >= budget)
      $display("FAIL wait_frames dut%0d: got still busy after %0d cycles, required idle", d, budget);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({tx[d], busy[d], rdy[d], done[d]} !== 4'b1010)
        $display("FAIL reset_values dut%0d: got tx/busy/ready/done %b, required 1010", d, {tx[d], busy[d], rdy[d], done[d]});
      else
        n_pass++;
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    tick_div = 1;
    start_frame(0, 8'hA5, 1'b0, 1'b0);
    wait_frames(0, 100);
    n_checks++;
    if (done_cyc[0] - acc_cyc[0] != 11)
      $display("FAIL basic_latency: got %0d clk, required 11", done_cyc[0] - acc_cyc[0]);
    else
      n_pass++;
  endtask

  task automatic test_parity;
    tick_div = 1;
    for (int t = 0; t < 2; t++) begin
      start_frame(0, 8'h07, 1'b1, t[0]);
      wait_frames(0, 100);
      n_checks++;
      if (done_cyc[0] - acc_cyc[0] != 12)
        $display("FAIL parity_latency typ%0d: got %0d clk, required 12", t, done_cyc[0] - acc_cyc[0]);
      else
        n_pass++;
    end
  endtask

  task automatic test_slow_tick;
    tick_div = 4;
    start_frame(0, 8'hC3, 1'b1, 1'b1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k % 3 == 0) begin
        dv[0]  = 1'b1;
        pdata0 = 8'($urandom);
        n_checks++;
        if (rdy[0] !== 1'b0)
          $display("FAIL slow_ready_midframe k%0d: got %b, required 0", k, rdy[0]);
        else
          n_pass++;
      end else begin
        dv[0] = 1'b0;
      end
    end
    dv[0] = 1'b0;
    wait_frames(0, 300);
    tick_div = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_msb_two_stop;
    tick_div = 1;
    start_frame(1, 8'h80, 1'b0, 1'b0);
    wait_frames(1, 100);
    n_checks++;
    if (done_cyc[1] - acc_cyc[1] != 12)
      $display("FAIL msb_latency: got %0d clk, required 12", done_cyc[1] - acc_cyc[1]);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    tick_div = 1;
    start_frame(0, 8'h5A, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rstn = 1'b0;
    q0.delete();
    #1;
    n_checks++;
    if ({tx[0], busy[0], rdy[0], done[0]} !== 4'b1010)
      $display("FAIL async_reset: got tx/busy/ready/done %b, required 1010", {tx[0], busy[0], rdy[0], done[0]});
    else
      n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(0, 8'h3C, 1'b0, 1'b0);
    wait_frames(0, 100);
    n_checks++;
    if (done_cyc[0] - acc_cyc[0] != 11)
      $display("FAIL post_reset_latency: got %0d clk, required 11", done_cyc[0] - acc_cyc[0]);
    else
      n_pass++;
  endtask

  task automatic test_back_to_back;
    int base;
    int a0;
    int a1;
    int k;
    tick_div = 1;
    push_frame(0, 8'h55, 1'b0, 1'b0);
    push_frame(0, 8'hAA, 1'b0, 1'b0);
    base = acc_cnt[0];
    @(negedge clk);
    dv[0] = 1'b1; pdata0 = 8'h55; pen[0] = 1'b0; ptyp[0] = 1'b0;
    k = 0;
    while (acc_cnt[0] == base && k < 10) begin @(negedge clk); k++; end
    a0 = acc_cyc[0];
    pdata0 = 8'hAA;
    k = 0;
    while (acc_cnt[0] == base + 1 && k < 40) begin @(negedge clk); k++; end
    a1 = acc_cyc[0];
    dv[0] = 1'b0;
    wait_frames(0, 100);
    n_checks++;
    if (a1 - a0 != 12)
      $display("FAIL b2b_spacing: got %0d clk between acceptances, required 12", a1 - a0);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_slow_tick();
    test_msb_two_stop();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
